// File: rtl/img_pipe_pkg.sv
// Shared constants and helpers for the image-processing pipeline blocks
// (output buffer, line-buffer controller, Sobel core).
package img_pipe_pkg;

    localparam int PIX_W          = 8;
    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// First-word-fall-through synchronous FIFO: RAM, pointers, fill counter and
// full/empty flags. Requests are qualified internally against full/empty.
module sync_fifo_core
    import img_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_fill
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_fill;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;

    // Flags come only from the registered count, so a read in the same cycle
    // never frees space for a write while full.
    assign w_full  = (r_fill == CNT_W'(DEPTH));
    assign w_empty = (r_fill == '0);
    assign w_wr    = i_wr && !w_full;
    assign w_rd    = i_rd && !w_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_fill    = r_fill;

endmodule

// File: rtl/axis_frame_out_buffer.sv
// AXI4-Stream output stage: buffers pixels and adds video framing (tuser = SOF,
// tlast = EOL), programmable-full backpressure, sticky overflow and frame-done IRQ.
module axis_frame_out_buffer
    import img_pipe_pkg::*;
#(
    parameter int DATA_W           = PIX_W,
    parameter int DEPTH            = 32,
    parameter int PROG_FULL_THRESH = 24,
    parameter int IMG_WIDTH        = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT       = IMG_HEIGHT_DEF,
    localparam int CNT_W           = clog2(DEPTH) + 1
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              m_axis_tready,
    output logic              o_prog_full,
    output logic [CNT_W-1:0]  o_fill_level,
    output logic              o_overflow,
    input  logic              i_clear_overflow,
    output logic              o_intr
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? clog2(IMG_HEIGHT) : 1;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_fill;
    logic             w_rd;
    logic             w_col_last;
    logic             w_row_last;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_overflow;
    logic             r_intr;

    // Handshake: a beat transfers on an edge where valid && ready. The slave
    // side ignores ready (the source may push while full; those beats drop);
    // the master side holds data/tlast/tuser stable until the transfer.
    assign w_rd = m_axis_tvalid && m_axis_tready;

    sync_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .i_clk     (axi_clk),
        .i_rst_n   (axi_reset_n),
        .i_wr      (s_axis_tvalid),
        .i_wr_data (s_axis_tdata),
        .i_rd      (w_rd),
        .o_rd_data (m_axis_tdata),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_fill    (w_fill)
    );

    assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_overflow <= 1'b0;
            r_intr     <= 1'b0;
        end else begin
            if (w_rd) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A new drop in the same cycle as a clear keeps the flag set.
            if (s_axis_tvalid && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end
            r_intr <= w_rd && w_col_last && w_row_last;
        end
    end

    assign s_axis_tready = !w_full;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tlast  = w_col_last;
    assign m_axis_tuser  = (r_col == '0) && (r_row == '0);
    assign o_prog_full   = (w_fill >= CNT_W'(PROG_FULL_THRESH));
    assign o_fill_level  = w_fill;
    assign o_overflow    = r_overflow;
    assign o_intr        = r_intr;

endmodule

// File: tb/tb_axis_frame_out_buffer.sv
// Self-checking bench for axis_frame_out_buffer with a 4x3 frame and a
// 32-deep FIFO; a queue model predicts every output beat and status flag.
module tb_axis_frame_out_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int THRESH = 24;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int CNT_W  = 6;

    logic              axi_clk = 1'b0;
    logic              axi_reset_n = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tready;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              m_axis_tready = 1'b0;
    logic              o_prog_full;
    logic [CNT_W-1:0]  o_fill_level;
    logic              o_overflow;
    logic              i_clear_overflow = 1'b0;
    logic              o_intr;

    // Model state: queue entries are {eof, tuser, tlast, tdata}.
    logic [DATA_W+2:0] exp_q[$];
    int                wr_cnt = 0;
    logic              ovf_m  = 1'b0;
    logic              intr_m = 1'b0;
    int                vectors = 0;
    int                miscompares = 0;

    axis_frame_out_buffer #(
        .DATA_W           (DATA_W),
        .DEPTH            (DEPTH),
        .PROG_FULL_THRESH (THRESH),
        .IMG_WIDTH        (IMG_W),
        .IMG_HEIGHT       (IMG_H)
    ) dut (
        .axi_clk          (axi_clk),
        .axi_reset_n      (axi_reset_n),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tready    (m_axis_tready),
        .o_prog_full      (o_prog_full),
        .o_fill_level     (o_fill_level),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow),
        .o_intr           (o_intr)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        wr_cnt = 0;
        ovf_m  = 1'b0;
        intr_m = 1'b0;
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, then
    // advance the model to match the next rising edge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
        int n;
        int pos;
        logic full_m, wr, rd;
        logic [DATA_W+2:0] ent;
        s_axis_tvalid    = v;
        s_axis_tdata     = d;
        m_axis_tready    = rdy;
        i_clear_overflow = clr;
        @(negedge axi_clk);
        n = exp_q.size();
        chk("s_tready",  32'(s_axis_tready), 32'(n < DEPTH));
        chk("fill",      32'(o_fill_level),  32'(n));
        chk("prog_full", 32'(o_prog_full),   32'(n >= THRESH));
        chk("m_tvalid",  32'(m_axis_tvalid), 32'(n > 0));
        chk("overflow",  32'(o_overflow),    32'(ovf_m));
        chk("intr",      32'(o_intr),        32'(intr_m));
        if (n > 0) begin
            ent = exp_q[0];
            chk("head_beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(ent[DATA_W+1:0]));
        end
        full_m = (n == DEPTH);
        wr     = v && !full_m;
        rd     = rdy && (n > 0);
        ovf_m  = (v && full_m) ? 1'b1 : (clr ? 1'b0 : ovf_m);
        intr_m = rd && exp_q[0][DATA_W+2];
        if (rd) void'(exp_q.pop_front());
        if (wr) begin
            pos = wr_cnt % (IMG_W * IMG_H);
            exp_q.push_back({(pos == IMG_W * IMG_H - 1), (pos == 0), ((pos % IMG_W) == IMG_W - 1), d});
            wr_cnt++;
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        axi_reset_n      = 1'b0;
        s_axis_tvalid    = 1'b0;
        m_axis_tready    = 1'b0;
        i_clear_overflow = 1'b0;
        model_clear();
        repeat (2) @(posedge axi_clk);
        #1;
        axi_reset_n = 1'b1;
    endtask

    task automatic drain(input logic random_ready);
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
            cyc(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drained_fill", 32'(o_fill_level), 32'd0);
    endtask

    initial begin
        // Reset values
        do_reset();
        @(negedge axi_clk);
        chk("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast",    32'(m_axis_tlast),  32'd0);
        chk("rst_tuser",    32'(m_axis_tuser),  32'd1);
        chk("rst_progfull", 32'(o_prog_full),   32'd0);
        chk("rst_fill",     32'(o_fill_level),  32'd0);
        chk("rst_overflow", 32'(o_overflow),    32'd0);
        chk("rst_intr",     32'(o_intr),        32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd1);
        @(posedge axi_clk);
        #1;

        // Single write, one-cycle latency, read back
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full with no reads, then one dropped beat
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        end
        // Clear coinciding with a new overflow, then a clear alone
        cyc(1'b1, 8'hDD, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        // Read while full refuses the write; next cycle the write lands
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        cyc(1'b1, 8'hEF, 1'b1, 1'b0);
        drain(1'b0);

        // Framing over a 4x3 frame plus one beat, with random stalls
        do_reset();
        for (int i = 0; i < IMG_W * IMG_H + 1; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain(1'b1);

        // Asynchronous reset mid-line with five entries buffered
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_abort_fill", 32'(o_fill_level), 32'd5);
        #2;
        axi_reset_n = 1'b0;
        #1;
        chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("abort_fill",   32'(o_fill_level),  32'd0);
        chk("abort_tuser",  32'(m_axis_tuser),  32'd1);
        chk("abort_intr",   32'(o_intr),        32'd0);
        model_clear();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge axi_clk);
        #1;
        axi_reset_n = 1'b1;
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
